// File: rtl/barrel_pool_vert.sv
// barrel_pool_vert
// Pool of N_BARRELS independent barrels that drop straight down from Kong.
// Each slot runs a two-state FSM (ST_IDLE / ST_FALL). A spawn request claims
// the lowest free slot. The barrel then falls under a saturating velocity
// that is updated once every TICK_DIV cycles. It ends on the floor, or when
// it overlaps Donkey if the hit test is compiled in.
//
// Configuration macro: BARREL_POOL_HIT_EN
//   defined   -> barrel/Donkey overlap test ends a fall and pulses barrel_hit
//   undefined -> barrel_hit is tied low; barrels end only at FLOOR_Y
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   barrel       spawn request, sampled every cycle
//   xpos_kong    Kong x position (spawn x = xpos_kong + X_OFFSET)
//   xpos_donkey  Donkey x position (hit test)
//   ypos_donkey  Donkey y position (hit test)
//   active       per-slot: slot is in ST_FALL (this is also the FSM state view)
//   xpos, ypos   per-slot 11-bit positions, slot i at [11i+10:11i]; 0 when idle
//   done         per-slot 1-cycle pulse when a fall ends (floor or hit)
//   barrel_hit   per-slot 1-cycle pulse when a fall ends on Donkey
//   spawn_drop   1-cycle pulse when a request found every slot busy
module barrel_pool_vert #(
  parameter int N_BARRELS = 4,
  parameter int TICK_DIV  = 400000,
  parameter int SPAWN_Y   = 160,
  parameter int FLOOR_Y   = 736,
  parameter int VMAX      = 12,
  parameter int X_OFFSET  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      barrel,
  input  logic [10:0]               xpos_kong,
  input  logic [10:0]               xpos_donkey,
  input  logic [10:0]               ypos_donkey,
  output logic [N_BARRELS-1:0]      active,
  output logic [11*N_BARRELS-1:0]   xpos,
  output logic [11*N_BARRELS-1:0]   ypos,
  output logic [N_BARRELS-1:0]      done,
  output logic [N_BARRELS-1:0]      barrel_hit,
  output logic                      spawn_drop
);

  typedef enum logic {ST_IDLE = 1'b0, ST_FALL = 1'b1} state_t;

  localparam int              CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [11:0]     FLOOR12  = 12'(FLOOR_Y);
  localparam logic [10:0]     FLOOR11  = 11'(FLOOR_Y);
  localparam logic [10:0]     SPAWN11  = 11'(SPAWN_Y);
  localparam logic [10:0]     VMAX11   = 11'(VMAX);

  state_t        st    [N_BARRELS];
  logic [10:0]   x_q   [N_BARRELS];
  logic [10:0]   y_q   [N_BARRELS];
  logic [10:0]   v_q   [N_BARRELS];
  logic [CW-1:0] cnt_q [N_BARRELS];

  logic [N_BARRELS-1:0] claim;
  logic                 free_any;
  logic [N_BARRELS-1:0] hit;
  logic [11:0]          spawn_x;

  assign free_any = ~&active;
  assign spawn_x  = {1'b0, xpos_kong} + 12'(X_OFFSET);

  // One-hot claim of the lowest slot whose registered active bit is clear.
  // Using the registered bit means a slot that ends this cycle is only
  // claimable from the next cycle on.
  always_comb begin
    logic taken;
    taken = 1'b0;
    claim = '0;
    for (int i = 0; i < N_BARRELS; i++) begin
      if (!active[i] && !taken) begin
        claim[i] = 1'b1;
        taken    = 1'b1;
      end
    end
  end

`ifdef BARREL_POOL_HIT_EN
  // Bounding-box overlap against Donkey, all sums 12 bits so none can wrap.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_BARRELS; i++) begin
      hit[i] = (st[i] == ST_FALL) &&
               ({1'b0, x_q[i]} + 12'd28 >= {1'b0, xpos_donkey}) &&
               ({1'b0, x_q[i]} <= {1'b0, xpos_donkey} + 12'd44) &&
               ({1'b0, y_q[i]} + 12'd32 >= {1'b0, ypos_donkey}) &&
               ({1'b0, y_q[i]} <= {1'b0, ypos_donkey} + 12'd32);
    end
  end
`else
  assign hit = '0;
  logic unused_donkey;
  assign unused_donkey = ^{xpos_donkey, ypos_donkey};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      spawn_drop <= 1'b0;
      done       <= '0;
      barrel_hit <= '0;
      for (int i = 0; i < N_BARRELS; i++) begin
        st[i]    <= ST_IDLE;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        v_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      spawn_drop <= barrel && !free_any;
      for (int i = 0; i < N_BARRELS; i++) begin
        done[i]       <= 1'b0;
        barrel_hit[i] <= 1'b0;
        case (st[i])
          ST_FALL: begin
            // Hit is checked before the floor so a coincident floor landing
            // still reports as a hit, with a single done pulse.
            if (hit[i] || y_q[i] == FLOOR11) begin
              st[i]         <= ST_IDLE;
              done[i]       <= 1'b1;
              barrel_hit[i] <= hit[i];
              x_q[i]        <= '0;
              y_q[i]        <= '0;
              v_q[i]        <= '0;
              cnt_q[i]      <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              cnt_q[i] <= '0;
              if ({1'b0, y_q[i]} + {1'b0, v_q[i]} >= FLOOR12) begin
                y_q[i] <= FLOOR11;
              end else begin
                y_q[i] <= y_q[i] + v_q[i];
              end
              if (v_q[i] < VMAX11) begin
                v_q[i] <= v_q[i] + 11'd1;
              end
            end else begin
              cnt_q[i] <= cnt_q[i] + CW'(1);
            end
          end
          default: begin
            if (barrel && claim[i]) begin
              st[i]    <= ST_FALL;
              x_q[i]   <= spawn_x[10:0];
              y_q[i]   <= SPAWN11;
              v_q[i]   <= '0;
              cnt_q[i] <= '0;
            end
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < N_BARRELS; g++) begin : g_out
    assign active[g]         = (st[g] == ST_FALL);
    assign xpos[11*g +: 11]  = x_q[g];
    assign ypos[11*g +: 11]  = y_q[g];
  end

endmodule

// File: doc/barrel_pool_vert.md
BARREL_POOL_VERT -- requirements
Module: barrel_pool_vert

Interface
REQ-001 SHALL have parameter N_BARRELS, default 4: number of independent vertical-barrel slots (1..8).
REQ-002 SHALL have parameter TICK_DIV, default 400000: clock cycles per motion step (>=2).
REQ-003 SHALL have parameter SPAWN_Y, default 160: spawn y coordinate.
REQ-004 SHALL have parameter FLOOR_Y, default 736: landing y coordinate.
REQ-005 SHALL have parameter VMAX, default 12: terminal velocity, in pixels per step.
REQ-006 SHALL have parameter X_OFFSET, default 12: spawn x offset added to xpos_kong.
REQ-007 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port barrel, input, 1: spawn request, sampled every cycle.
REQ-010 SHALL have ports xpos_kong, xpos_donkey, ypos_donkey, input, 11 each: current positions of Kong and Donkey.
REQ-011 SHALL have port active, output, N_BARRELS: bit i is high while slot i is falling.
REQ-012 SHALL have ports xpos, ypos, output, N_BARRELS x 11 (slot i at bits [11i+10:11i]): barrel positions.
REQ-013 SHALL have port done, output, N_BARRELS: 1-cycle pulse when slot i ends, by floor or by hit.
REQ-014 SHALL have port barrel_hit, output, N_BARRELS: 1-cycle pulse when slot i hits Donkey.
REQ-015 SHALL have port spawn_drop, output, 1: 1-cycle pulse when a request finds no free slot.

Function
REQ-016 Each slot SHALL be an FSM with two states: ST_IDLE and ST_FALL; active[i] = (state == ST_FALL).
REQ-017 barrel high in cycle t SHALL claim the lowest-index slot whose registered active bit is 0; from t+1 that slot is in ST_FALL with xpos = xpos_kong + X_OFFSET (value at t), ypos = SPAWN_Y, velocity 0, counter 0.
REQ-018 A request SHALL claim at most one slot; if all active bits are 1 at t, spawn_drop SHALL pulse at t+1 and no slot changes.
REQ-019 A slot ending in cycle t SHALL NOT be claimable until t+1.
REQ-020 In ST_FALL, the counter SHALL increment every cycle. At counter == TICK_DIV-1, the counter SHALL clear, ypos SHALL become min(ypos + velocity, FLOOR_Y), and velocity SHALL become min(velocity + 1, VMAX).
REQ-021 xpos SHALL stay constant throughout ST_FALL.
REQ-022 All position sums SHALL be computed 12 bits wide; wrap-around is forbidden.
REQ-023 Hit test SHALL run every ST_FALL cycle on registered values: xpos+28 >= xpos_donkey, xpos <= xpos_donkey+44, ypos+32 >= ypos_donkey, and ypos <= ypos_donkey+32.
REQ-024 On a hit in cycle t, barrel_hit[i] and done[i] SHALL pulse at t+1 and the slot SHALL be in ST_IDLE at t+1.
REQ-025 On ypos == FLOOR_Y in ST_FALL at cycle t with no hit, done[i] SHALL pulse at t+1, barrel_hit[i] SHALL stay 0, and the slot SHALL be in ST_IDLE at t+1.
REQ-026 If hit and floor occur together, hit SHALL take priority; done SHALL pulse exactly once.
REQ-027 Multiple slots MAY end, and one slot MAY spawn, in the same cycle, each independently.
REQ-028 Idle slots SHALL drive xpos = 0, ypos = 0 and hold velocity and counter at 0.

Reset
REQ-029 rst high SHALL force all slots to ST_IDLE, all counters, velocities and positions to 0, and active, done, barrel_hit and spawn_drop to 0 on the next edge.
REQ-030 rst asserted mid-fall SHALL discard every barrel with no done pulse, and a barrel request coincident with rst SHALL be ignored.
REQ-031 Operation SHALL resume on the first cycle after rst deasserts.

Configuration
REQ-032 Macro BARREL_POOL_HIT_EN defined SHALL compile in the hit test of REQ-023 to REQ-026.
REQ-033 With BARREL_POOL_HIT_EN undefined, barrel_hit SHALL be tied to 0 and slots SHALL end only at FLOOR_Y; all other behaviour SHALL be identical.

Verification
REQ-034 Reset with TICK_DIV=4, N_BARRELS=2, xpos_kong=100, then pulse barrel -> next cycle active=01, xpos[0]=112, ypos[0]=160.
REQ-035 Single barrel, donkey far away (xpos_donkey=900) -> ypos steps 160,160,161,163,166... every 4 cycles, velocity saturates at 12, last step clamps to 736, done[0] pulses once, active[0] drops.
REQ-036 Three barrel pulses on consecutive cycles with N_BARRELS=2 -> slots 0 and 1 claimed, spawn_drop pulses exactly once on the third.
REQ-037 Donkey at (112,200) with a barrel falling from 160 -> barrel_hit[0] and done[0] pulse together on the first overlapping cycle, and the slot goes idle.
REQ-038 Same stimulus with BARREL_POOL_HIT_EN undefined -> barrel_hit stays 0 and the barrel reaches 736.
REQ-039 rst asserted while two barrels fall -> next cycle active=00, done=00, all positions 0, and a fresh spawn works one cycle after release.
